matvec_param: RTL and testbench

Parametrised M x N signed matrix-vector multiplier, the successor to the fixed 3x3 matvec block.
- Streams the matrix W (row-major) and then the vector x over one valid/ready input channel.
- Computes y = W*x with a single MAC, one row at a time.
- Streams the M results out over a valid/ready output channel.
- Adds matrix retention: a job may reuse the stored W and load only a new x.

---
 rtl/matvec_param.sv | 187 ++++++++++++++++++
 tb/tb_matvec_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_param.sv
// matvec_param: M x N signed matrix-vector multiplier with a single MAC.
// The matrix W (row-major) and then the vector x arrive on one valid/ready input channel.
// The block computes y = W*x one row at a time and streams y[0..M-1] out.
// Between jobs the stored W can be kept, so that a job loads only a new x.
module matvec_param #(
  parameter int unsigned M      = 3,
  parameter int unsigned N      = 3,
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_valid,
  output logic                     input_ready,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic                     reload_w,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic signed [ACC_W-1:0]  output_data
);

  localparam int unsigned WA_W  = $clog2(M * N);
  localparam int unsigned XA_W  = $clog2(N);
  localparam int unsigned RA_W  = $clog2(M);
  localparam int unsigned PR_W  = 2 * DATA_W;

  localparam logic [WA_W-1:0] WLast = WA_W'(M * N - 1);
  localparam logic [XA_W-1:0] XLast = XA_W'(N - 1);
  localparam logic [RA_W-1:0] RLast = RA_W'(M - 1);
  localparam logic [WA_W-1:0] NStep = WA_W'(N);

  typedef enum logic [1:0] {
    StLoadW,
    StLoadX,
    StMac,
    StOut
  } state_e;

  state_e                    r_state;
  logic [WA_W-1:0]           r_waddr;    // W write address while loading
  logic [XA_W-1:0]           r_xaddr;    // x write address while loading
  logic [RA_W-1:0]           r_row;      // current output row
  logic [WA_W-1:0]           r_wbase;    // row * N, kept incrementally
  logic [XA_W-1:0]           r_k;        // column of the next read
  logic                      r_issue;    // reads still to issue for this row
  logic                      r_rd_vld;   // a read was issued on the previous edge
  logic                      r_rd_last;  // that read was column N-1
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_in_rdy;
  logic                      r_out_vld;

  logic signed [DATA_W-1:0]  r_mem_w [M*N];
  logic signed [DATA_W-1:0]  r_mem_x [N];
  logic signed [DATA_W-1:0]  r_w_rd;
  logic signed [DATA_W-1:0]  r_x_rd;

  logic                      w_in_hs;
  logic                      w_out_hs;
  logic                      w_rd_en;
  logic [WA_W-1:0]           w_rd_addr;
  logic signed [PR_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;

  // Handshakes, read address and sign-extended product.
  always_comb begin
    w_in_hs    = input_valid & r_in_rdy;
    w_out_hs   = r_out_vld & output_ready;
    w_rd_en    = (r_state == StMac) & r_issue;
    w_rd_addr  = r_wbase + WA_W'(r_k);
    w_prod     = r_w_rd * r_x_rd;
    w_prod_ext = {{(ACC_W - PR_W){w_prod[PR_W-1]}}, w_prod};
  end

  // Operand memories: synchronous write, synchronous read, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_in_hs && (r_state == StLoadW)) begin
      r_mem_w[r_waddr] <= input_data;
    end
    if (w_in_hs && (r_state == StLoadX)) begin
      r_mem_x[r_xaddr] <= input_data;
    end
    if (w_rd_en) begin
      r_w_rd <= r_mem_w[w_rd_addr];
      r_x_rd <= r_mem_x[r_k];
    end
  end

  // Control FSM with counters, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StLoadW;
      r_waddr   <= '0;
      r_xaddr   <= '0;
      r_row     <= '0;
      r_wbase   <= '0;
      r_k       <= '0;
      r_issue   <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      r_acc     <= '0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      unique case (r_state)
        StLoadW: begin
          // Ready rises one cycle after entering from reset; no data is lost.
          r_in_rdy <= 1'b1;
          if (w_in_hs) begin
            if (r_waddr == WLast) begin
              r_waddr <= '0;
              r_state <= StLoadX;
            end else begin
              r_waddr <= r_waddr + WA_W'(1);
            end
          end
        end
        StLoadX: begin
          r_in_rdy <= 1'b1;
          if (w_in_hs) begin
            if (r_xaddr == XLast) begin
              r_xaddr   <= '0;
              r_in_rdy  <= 1'b0;
              r_state   <= StMac;
              r_acc     <= '0;
              r_k       <= '0;
              r_issue   <= 1'b1;
              r_rd_vld  <= 1'b0;
              r_rd_last <= 1'b0;
            end else begin
              r_xaddr <= r_xaddr + XA_W'(1);
            end
          end
        end
        StMac: begin
          // Product of the read issued last edge is accumulated this edge.
          if (r_rd_vld) begin
            r_acc <= r_acc + w_prod_ext;
          end
          if (r_issue) begin
            r_rd_vld  <= 1'b1;
            r_rd_last <= (r_k == XLast);
            if (r_k == XLast) begin
              r_k     <= '0;
              r_issue <= 1'b0;
            end else begin
              r_k <= r_k + XA_W'(1);
            end
          end else begin
            r_rd_vld <= 1'b0;
          end
          if (r_rd_vld && r_rd_last) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_out_vld <= 1'b1;
            r_state   <= StOut;
          end
        end
        StOut: begin
          if (w_out_hs) begin
            r_out_vld <= 1'b0;
            if (r_row == RLast) begin
              r_row    <= '0;
              r_wbase  <= '0;
              r_in_rdy <= 1'b1;
              r_state  <= reload_w ? StLoadW : StLoadX;
            end else begin
              r_row   <= r_row + RA_W'(1);
              r_wbase <= r_wbase + NStep;
              r_acc   <= '0;
              r_k     <= '0;
              r_issue <= 1'b1;
              r_state <= StMac;
            end
          end
        end
        default: begin
          r_state <= StLoadW;
        end
      endcase
    end
  end

  assign input_ready  = r_in_rdy;
  assign output_valid = r_out_vld;
  assign output_data  = r_acc;

endmodule

// File: tb/tb_matvec_param.sv
// Self-checking bench for matvec_param (M=N=3, DATA_W=14): table of directed jobs,
// hand-written backpressure and reset sequences, and randomized jobs against a model.
module tb_matvec_param;

  localparam int M  = 3;
  localparam int N  = 3;
  localparam int DW = 14;
  localparam int AW = 2 * DW + $clog2(N);

  typedef struct packed {
    logic [M*N-1:0][DW-1:0] w;
    logic [N-1:0][DW-1:0]   x;
    bit                     load_w;
    bit                     next_load;
    bit                     gaps;
    logic [M-1:0][AW-1:0]   y;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 input_valid;
  logic                 input_ready;
  logic signed [DW-1:0] input_data;
  logic                 reload_w;
  logic                 output_valid;
  logic                 output_ready;
  logic signed [AW-1:0] output_data;

  int checks = 0;
  int errors = 0;
  logic [M*N-1:0][DW-1:0] model_w;
  vec_t vecs [5];

  matvec_param #(.M(M), .N(N), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .reload_w     (reload_w),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // y = W*x in plain integer arithmetic.
  function automatic logic [M-1:0][AW-1:0] model(input logic [M*N-1:0][DW-1:0] w,
                                                 input logic [N-1:0][DW-1:0] x);
    logic [M-1:0][AW-1:0] y;
    for (int i = 0; i < M; i++) begin
      longint s = 0;
      for (int j = 0; j < N; j++) begin
        s += longint'($signed(w[i*N+j])) * longint'($signed(x[j]));
      end
      y[i] = AW'(s);
    end
    return y;
  endfunction

  // Present one element (optionally after random idle cycles) until it is accepted.
  task automatic send(input logic [DW-1:0] d, input bit gaps);
    int t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        input_valid = 1'b0;
        input_data  = DW'($urandom);
        @(negedge clk);
      end
    end
    input_valid = 1'b1;
    input_data  = d;
    while (!input_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("input_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    input_valid = 1'b0;
  endtask

  // Wait for output_valid while driving junk on the input channel, which must be ignored.
  task automatic wait_out(output int cnt, output bit ok);
    cnt = 0;
    while (!output_valid && cnt < 100) begin
      input_valid = 1'($urandom);
      input_data  = DW'($urandom);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    input_valid = 1'b0;
    ok = output_valid;
  endtask

  task automatic load_job(input vec_t v);
    input_valid = 1'b0;
    if (v.load_w) begin
      for (int i = 0; i < M * N; i++) send(v.w[i], v.gaps);
      model_w = v.w;
    end
    for (int j = 0; j < N; j++) send(v.x[j], v.gaps);
    check("input_ready_after_last_x", input_ready, 0);
  endtask

  task automatic collect(input vec_t v, input bit rnd, input bit lat, input string name);
    int cnt;
    bit ok;
    for (int r = 0; r < M; r++) begin
      wait_out(cnt, ok);
      if (!ok) begin
        check($sformatf("%s_row%0d_timeout", name, r), 0, 1);
        return;
      end
      if (lat) check($sformatf("%s_row%0d_latency", name, r), cnt, N + 1);
      check($sformatf("%s_row%0d_in_ready", name, r), input_ready, 0);
      output_ready = rnd ? 1'($urandom) : 1'b1;
      while (!output_ready) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s_row%0d_hold_valid", name, r), output_valid, 1);
        check($sformatf("%s_row%0d_hold_data", name, r), $signed(output_data),
              $signed(v.y[r]));
        output_ready = 1'($urandom);
      end
      check($sformatf("%s_row%0d_data", name, r), $signed(output_data), $signed(v.y[r]));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_row%0d_valid_fall", name, r), output_valid, 0);
    end
    output_ready = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit rnd, input bit lat, input string name);
    reload_w = v.next_load;
    output_ready = 1'b1;
    load_job(v);
    collect(v, rnd, lat, name);
  endtask

  initial begin
    vec_t bp;
    bit   prev_next;
    int   cnt;
    bit   ok;

    // Directed job table.
    for (int i = 0; i < M * N; i++) vecs[0].w[i] = DW'(i + 1);
    vecs[0].x = {DW'(3), DW'(2), DW'(1)};
    vecs[0].load_w = 1; vecs[0].next_load = 0; vecs[0].gaps = 0;
    vecs[0].y = {AW'(50), AW'(32), AW'(14)};

    vecs[1] = vecs[0];
    vecs[1].x = {DW'(1), DW'(0), DW'(-1)};
    vecs[1].load_w = 0; vecs[1].next_load = 1;
    vecs[1].y = {AW'(2), AW'(2), AW'(2)};

    for (int i = 0; i < M * N; i++) vecs[2].w[i] = DW'(-8192);
    vecs[2].x = {DW'(-8192), DW'(-8192), DW'(-8192)};
    vecs[2].load_w = 1; vecs[2].next_load = 1; vecs[2].gaps = 0;
    vecs[2].y = {AW'(201326592), AW'(201326592), AW'(201326592)};

    vecs[3] = vecs[2];
    vecs[3].x = {DW'(8191), DW'(8191), DW'(8191)};
    vecs[3].y = {AW'(-201302016), AW'(-201302016), AW'(-201302016)};

    vecs[4] = vecs[0];
    vecs[4].next_load = 1; vecs[4].gaps = 1;

    reset = 1'b0;
    input_valid = 1'b0;
    input_data = '0;
    reload_w = 1'b1;
    output_ready = 1'b1;
    #1;
    check("reset_input_ready", input_ready, 0);
    check("reset_output_valid", output_valid, 0);
    check("reset_output_data", output_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_vec(vecs[t], 0, 1, $sformatf("table%0d", t));

    // Backpressure on row 0.
    bp = vecs[0];
    bp.next_load = 1;
    reload_w = 1'b1;
    load_job(bp);
    wait_out(cnt, ok);
    check("bp_row0_latency", cnt, N + 1);
    output_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", output_valid, 1);
      check("bp_hold_data", $signed(output_data), 14);
    end
    output_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_out(cnt, ok);
    check("bp_row1_latency", cnt, N + 1);
    check("bp_row1_data", $signed(output_data), 32);
    @(posedge clk);
    @(negedge clk);
    wait_out(cnt, ok);
    check("bp_row2_data", $signed(output_data), 50);
    @(posedge clk);
    @(negedge clk);

    // Randomized jobs against the model, with random output stalls.
    prev_next = 1'b1;
    for (int t = 0; t < 8; t++) begin
      vec_t v;
      v.load_w = prev_next;
      v.next_load = (t == 7) ? 1'b1 : 1'($urandom);
      v.gaps = 1'b1;
      if (v.load_w) begin
        for (int i = 0; i < M * N; i++) v.w[i] = DW'($urandom);
      end else begin
        v.w = model_w;
      end
      for (int j = 0; j < N; j++) v.x[j] = DW'($urandom);
      v.y = model(v.w, v.x);
      run_vec(v, 1, 0, $sformatf("rand%0d", t));
      prev_next = v.next_load;
    end

    // Reset in the middle of row 1's MAC phase.
    reload_w = 1'b1;
    load_job(vecs[0]);
    wait_out(cnt, ok);
    check("rst_row0_data", $signed(output_data), 14);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_output_valid", output_valid, 0);
    check("rst_mid_input_ready", input_ready, 0);
    check("rst_mid_output_data", output_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    while (!input_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_release_input_ready", input_ready, 1);
    run_vec(vecs[4], 0, 1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
